// File: rtl/vmx_row_feeder.sv
// vmx_row_feeder
// Transmitting head of one PE row in the vector-matrix engine. Accepts NUM_PE
// weight words followed by cfg_vec_count vector words from a valid/ready
// source. Each weight k is sent with the token 8'h80|k so that it lands in PE k.
// Vector words are then streamed with the neutral token 8'h7F. Finally the
// feeder waits NUM_PE cycles for the chain to drain and pulses done.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_start         start pulse (honoured only when idle)
//   cfg_simd_mode     0 = 16-bit, 1 = dual 8-bit (latched on start)
//   cfg_vec_count     vector words after the weights (latched on start)
//   busy, done        job in progress / one-cycle completion pulse
//   s_tdata/s_tvalid/s_tready  input word stream (weights, then vector)
//   pe_simd_mode, pe_load_ctrl, pe_data  registered outputs to PE0
//   pe_valid          pe_data carries a real word this cycle
module vmx_row_feeder #(
  parameter int VECTOR_BITLEN = 16,
  parameter int NUM_PE        = 8,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_simd_mode,
  input  logic [CNT_W-1:0]         cfg_vec_count,
  output logic                     busy,
  output logic                     done,
  input  logic [VECTOR_BITLEN-1:0] s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic                     pe_simd_mode,
  output logic [7:0]               pe_load_ctrl,
  output logic [VECTOR_BITLEN-1:0] pe_data,
  output logic                     pe_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  localparam logic [6:0] LAST_PE    = 7'(NUM_PE - 1);
  // 8'h7F decays by one per PE and cannot reach 8'h80 within 127 PEs.
  localparam logic [7:0] IDLE_TOKEN = 8'h7F;

  state_t                   state_reg, state_next;
  logic [6:0]               k_reg, k_next;
  logic [6:0]               drain_reg, drain_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [CNT_W-1:0]         vec_count_reg, vec_count_next;
  logic                     simd_reg, simd_next;
  logic                     done_reg, done_next;
  logic                     valid_reg, valid_next;
  logic [7:0]               ctrl_reg, ctrl_next;
  logic [VECTOR_BITLEN-1:0] data_reg, data_next;
  logic                     hs;

  assign s_tready     = (state_reg == LOAD) || (state_reg == STREAM);
  assign hs           = s_tready && s_tvalid;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign pe_simd_mode = simd_reg;
  assign pe_load_ctrl = ctrl_reg;
  assign pe_data      = data_reg;
  assign pe_valid     = valid_reg;

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    cnt_next       = cnt_reg;
    drain_next     = drain_reg;
    vec_count_next = vec_count_reg;
    simd_next      = simd_reg;
    done_next      = 1'b0;
    // Bubble / idle output unless a word is accepted this cycle.
    valid_next     = 1'b0;
    ctrl_next      = IDLE_TOKEN;
    data_next      = '0;
    if (hs) begin
      valid_next = 1'b1;
      data_next  = s_tdata;
    end

    case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          simd_next      = cfg_simd_mode;
          vec_count_next = cfg_vec_count;
          k_next         = '0;
          cnt_next       = '0;
          drain_next     = '0;
          state_next     = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          ctrl_next = 8'h80 | {1'b0, k_reg};
          k_next    = k_reg + 7'd1;
          if (k_reg == LAST_PE)
            state_next = (vec_count_reg == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == vec_count_reg - 1'b1)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        // NUM_PE cycles lets the last word clear the final PE.
        if (drain_reg == LAST_PE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          drain_next = drain_reg + 7'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      cnt_reg       <= '0;
      drain_reg     <= '0;
      vec_count_reg <= '0;
      simd_reg      <= 1'b0;
      done_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      ctrl_reg      <= IDLE_TOKEN;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      cnt_reg       <= cnt_next;
      drain_reg     <= drain_next;
      vec_count_reg <= vec_count_next;
      simd_reg      <= simd_next;
      done_reg      <= done_next;
      valid_reg     <= valid_next;
      ctrl_reg      <= ctrl_next;
      data_reg      <= data_next;
    end
  end

endmodule

// File: tb/tb_vmx_row_feeder.sv
// Bench for vmx_row_feeder: a 4-PE and a 127-PE instance share the stimulus,
// each with its own start. Expected tokens come from the word index rule, and
// a behavioural PE chain checks where each weight finally lands.
module tb_vmx_row_feeder;
  localparam int W  = 16;
  localparam int CW = 16;
  localparam int NA = 4;
  localparam int NB = 127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a, start_b, cfg_simd_mode, s_tvalid;
  logic [CW-1:0] cfg_vec_count;
  logic [W-1:0]  s_tdata;

  logic a_busy, a_done, a_ready, a_mode, a_valid;
  logic b_busy, b_done, b_ready, b_mode, b_valid;
  logic [7:0]   a_ctrl, b_ctrl;
  logic [W-1:0] a_data, b_data;

  vmx_row_feeder #(.VECTOR_BITLEN(W), .NUM_PE(NA), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_a), .cfg_simd_mode(cfg_simd_mode),
    .cfg_vec_count(cfg_vec_count), .busy(a_busy), .done(a_done),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(a_ready),
    .pe_simd_mode(a_mode), .pe_load_ctrl(a_ctrl), .pe_data(a_data), .pe_valid(a_valid));

  vmx_row_feeder #(.VECTOR_BITLEN(W), .NUM_PE(NB), .CNT_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_start(start_b), .cfg_simd_mode(cfg_simd_mode),
    .cfg_vec_count(cfg_vec_count), .busy(b_busy), .done(b_done),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(b_ready),
    .pe_simd_mode(b_mode), .pe_load_ctrl(b_ctrl), .pe_data(b_data), .pe_valid(b_valid));

  // Selected instance view.
  logic         sel = 1'b0;
  logic         o_busy, o_done, o_ready, o_mode, o_valid;
  logic [7:0]   o_ctrl;
  logic [W-1:0] o_data;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_mode  = sel ? b_mode  : a_mode;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_ctrl  = sel ? b_ctrl  : a_ctrl;
  assign o_data  = sel ? b_data  : a_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] words[$];

  // Behavioural PE chain: each PE registers (token, data) and loads on 8'h80.
  int          m_n;
  logic [7:0]  m_ctrl[NB];
  logic [W-1:0] m_data[NB];
  logic [W-1:0] m_w[NB];
  int          m_loads[NB];

  task automatic pe_clear(input int n);
    m_n = n;
    for (int p = 0; p < NB; p++) begin
      m_ctrl[p] = 8'h7F; m_data[p] = '0; m_w[p] = '0; m_loads[p] = 0;
    end
  endtask

  task automatic pe_step(input logic [7:0] c, input logic [W-1:0] d);
    logic [7:0]   in_c;
    logic [W-1:0] in_d;
    for (int p = m_n - 1; p >= 0; p--) begin
      in_c = (p == 0) ? c : m_ctrl[p-1];
      in_d = (p == 0) ? d : m_data[p-1];
      if (in_c == 8'h80) begin
        m_w[p] = in_d; m_loads[p]++; m_ctrl[p] = 8'h7F;
      end else begin
        m_ctrl[p] = in_c - 8'd1;
      end
      m_data[p] = in_d;
    end
  endtask

  task automatic set_start(input logic v);
    start_a = sel ? 1'b0 : v;
    start_b = sel ? v : 1'b0;
  endtask

  // One job on the selected instance. vmode: 0 constant valid, 1 random
  // valid, 2 two-cycle bubble after the second weight. inject_at >= 0 pulses
  // cfg_start with a different config at that loop cycle.
  task automatic run_job(input string name, input logic mode, input int count,
                         input int vmode, input int inject_at);
    int n, total, accepted, cyc, bubbles;
    logic v;
    logic [7:0]   exp_c;
    logic [W-1:0] exp_d;
    n = sel ? NB : NA;
    total = n + count;
    accepted = 0; cyc = 0; bubbles = 2;
    while (words.size() < total) words.push_back(W'($urandom));
    pe_clear(n);
    @(negedge clk);
    cfg_simd_mode = mode;
    cfg_vec_count = CW'(count);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    cfg_simd_mode = ~mode;
    cfg_vec_count = CW'($urandom);
    checks++;
    if (o_busy !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0 || o_mode !== mode) begin
      errors++;
      $display("FAIL %s start: busy=%b ready=%b done=%b mode=%b, want 1 1 0 %b",
               name, o_busy, o_ready, o_done, o_mode, mode);
    end
    while (accepted < total) begin
      if (cyc > 5000) begin
        errors++; checks++;
        $display("FAIL %s timeout: accepted %0d of %0d", name, accepted, total);
        return;
      end
      if (cyc > 0) @(negedge clk);
      case (vmode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 3) != 0);
        default: begin
          v = 1'b1;
          if (accepted == 2 && bubbles > 0) begin v = 1'b0; bubbles--; end
        end
      endcase
      s_tvalid = v;
      s_tdata  = v ? words[accepted] : W'($urandom);
      if (cyc == inject_at) begin
        cfg_simd_mode = ~mode;
        cfg_vec_count = CW'(count + 5);
        set_start(1'b1);
      end
      checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s ready word %0d: ready=%b busy=%b, want 1 1", name, accepted, o_ready, o_busy);
      end
      @(posedge clk);
      #1;
      set_start(1'b0);
      exp_d = v ? words[accepted] : '0;
      exp_c = (v && accepted < n) ? 8'(8'h80 | accepted) : 8'h7F;
      checks++;
      if (o_ctrl !== exp_c || o_data !== exp_d || o_valid !== v || o_mode !== mode) begin
        errors++;
        $display("FAIL %s out cyc %0d: ctrl=%h data=%h valid=%b mode=%b, want %h %h %b %b",
                 name, cyc, o_ctrl, o_data, o_valid, o_mode, exp_c, exp_d, v, mode);
      end
      pe_step(o_ctrl, o_data);
      if (v) accepted++;
      cyc++;
    end
    // Drain: done must land exactly n cycles after the last pe_valid cycle.
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      s_tvalid = $urandom_range(0, 1);
      s_tdata  = W'($urandom);
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s drain ready %0d: got %b want 0", name, i, o_ready);
      end
      @(posedge clk);
      #1;
      pe_step(o_ctrl, o_data);
      checks++;
      if (o_done !== (i == n) || o_busy !== (i != n) || o_valid !== 1'b0 ||
          o_ctrl !== 8'h7F || o_data !== '0 || o_mode !== mode) begin
        errors++;
        $display("FAIL %s drain %0d: done=%b busy=%b valid=%b ctrl=%h data=%h mode=%b, want %b %b 0 7f 0 %b",
                 name, i, o_done, o_busy, o_valid, o_ctrl, o_data, o_mode, i == n, i != n, mode);
      end
    end
    for (int p = 0; p < n; p++) begin
      checks++;
      if (m_loads[p] !== 1 || m_w[p] !== words[p]) begin
        errors++;
        $display("FAIL %s pe%0d: loads=%0d weight=%h, want 1 %h", name, p, m_loads[p], m_w[p], words[p]);
      end
    end
    $display("%s: %0d words, mode %b, done after drain", name, total, mode);
    words.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (o_ctrl !== 8'h7F || o_data !== '0 || o_ready !== 1'b0 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_valid !== 1'b0 || o_mode !== 1'b0) begin
      errors++;
      $display("FAIL %s: ctrl=%h data=%h ready=%b busy=%b done=%b valid=%b mode=%b, want 7f 0 0 0 0 0 0",
               name, o_ctrl, o_data, o_ready, o_busy, o_done, o_valid, o_mode);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a = $urandom_range(0, 1); start_b = $urandom_range(0, 1);
      cfg_simd_mode = $urandom_range(0, 1); cfg_vec_count = CW'($urandom);
      s_tvalid = $urandom_range(0, 1); s_tdata = W'($urandom);
    end
    #1;
    sel = 1'b0; #1; check_idle_outputs("reset_a");
    sel = 1'b1; #1; check_idle_outputs("reset_b");
    sel = 1'b0;
    @(negedge clk);
    start_a = 0; start_b = 0; s_tvalid = 0; cfg_simd_mode = 0; cfg_vec_count = '0;
    rst_n = 1'b1;
    $display("reset: outputs idle under random inputs");
  endtask

  task automatic test_basic();
    words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0101, 16'h0202};
    run_job("basic", 1'b0, 2, 0, -1);
  endtask

  task automatic test_bubbles();
    words = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0B01, 16'h0B02, 16'h0B03};
    run_job("bubbles", 1'b0, 3, 2, -1);
  endtask

  task automatic test_zero_count();
    run_job("zero_count", 1'b1, 0, 0, -1);
  endtask

  task automatic test_ignored_start();
    run_job("ignored_start", 1'b1, 4, 0, 6);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++)
      run_job("back_to_back", 1'($urandom_range(0, 1)), $urandom_range(0, 6), 1, -1);
  endtask

  task automatic test_full127();
    sel = 1'b1;
    run_job("full127", 1'b1, 2, 1, -1);
    sel = 1'b0;
  endtask

  task automatic test_async_reset();
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    @(negedge clk);
    cfg_simd_mode = 1'b1; cfg_vec_count = CW'(5); start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tdata = words[i];
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    words.delete();
    $display("async_reset: outputs cleared without a clock edge");
  endtask

  initial begin
    start_a = 0; start_b = 0; cfg_simd_mode = 0; cfg_vec_count = '0;
    s_tvalid = 0; s_tdata = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_count();
    test_ignored_start();
    test_back_to_back();
    test_full127();
    test_async_reset();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vmx_row_feeder.md
Name: vmx_row_feeder

Overview:
- Drives the head of one PE row in the vector-matrix engine, i.e. the transmitting end of the PE chain's data/load_ctrl/simd_mode interface.
- Accepts a stream of NUM_PE weight words followed by vector words from a valid/ready source, and generates the per-cycle load_ctrl tokens that place weight k into PE k.
- Streams the vector words through the row, then waits for the chain to drain and signals done.

Parameters:
- VECTOR_BITLEN, 16, width of weight and vector words.
- NUM_PE, 8, PEs in the driven row; legal range 1..127.
- CNT_W, 16, width of the vector word count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle start pulse, honoured only in IDLE.
- cfg_simd_mode  in  1  0 = 16-bit mode, 1 = dual 8-bit mode; latched on start.
- cfg_vec_count  in  CNT_W  vector words to stream after the weights; latched on start.
- busy  out  1  high in LOAD, STREAM and DRAIN.
- done  out  1  one-cycle completion pulse.
- s_tdata  in  VECTOR_BITLEN  input word (weights first, then vector).
- s_tvalid  in  1  source valid.
- s_tready  out  1  feeder ready.
- pe_simd_mode  out  1  to PE0 simd_mode.
- pe_load_ctrl  out  8  to PE0 load_ctrl.
- pe_data  out  VECTOR_BITLEN  to PE0 data.
- pe_valid  out  1  pe_data carries a real word this cycle (sideband for the row collector).

Behaviour:
- Reset values: busy=0, done=0, s_tready=0, pe_simd_mode=0, pe_load_ctrl=8'h7F, pe_data=0, pe_valid=0, state=IDLE, counters=0.
- Reset asserted mid-operation returns everything to these values immediately. Partially loaded weights are abandoned.
- PE token rule: a PE loads when it sees 8'h80. Otherwise it passes load_ctrl-1, or 8'h7F after loading.
  - A token of 8'h80|k sent at PE0 lands at PE k.
  - The idle/stream token is 8'h7F, which cannot decay to 8'h80 within 127 PEs.
- All pe_* outputs are registered: each reflects the input handshake of the previous cycle (1-cycle latency). s_tready is combinational from state.
- FSM states:
  - IDLE:
    - s_tready=0; pe_load_ctrl=8'h7F, pe_data=0, pe_valid=0.
    - On cfg_start: latch simd_mode and vec_count, clear k and cnt, go to LOAD.
  - LOAD:
    - s_tready=1.
    - On handshake: pe_data<=s_tdata, pe_load_ctrl<=8'h80|k, pe_valid<=1, k<=k+1.
    - On handshake with k==NUM_PE-1: go to STREAM, or to DRAIN if the latched vec_count==0.
    - No handshake (bubble): pe_data<=0, pe_load_ctrl<=8'h7F, pe_valid<=0, k unchanged.
  - STREAM:
    - s_tready=1.
    - On handshake: pe_data<=s_tdata, pe_load_ctrl<=8'h7F, pe_valid<=1, cnt<=cnt+1.
    - On handshake with cnt==vec_count-1: go to DRAIN.
    - Bubble: same as in LOAD.
  - DRAIN:
    - s_tready=0; outputs idle as in IDLE.
    - Drain counter runs NUM_PE cycles.
    - At the end: done=1 for exactly one cycle while entering IDLE; busy=0 from that same cycle.
- pe_simd_mode holds the latched mode from the cycle after cfg_start through DRAIN. It keeps its value in IDLE until the next start.
- cfg_start while busy is ignored: no relatch, no state change.
- cfg_start coincident with done is not possible, because done occurs on entry to IDLE. A start in the first IDLE cycle is honoured.
- Counters never wrap. A vec_count of 2^CNT_W-1 is legal.

Test Plan:
- Reset: hold rst_n=0 with random inputs → pe_load_ctrl=8'h7F, pe_data=0, s_tready=0, busy=0, done=0. Assert rst_n asynchronously mid-STREAM → same values with no clock edge needed.
- NUM_PE=4, start with vec_count=2; stream 0x0011, 0x0022, 0x0033, 0x0044, 0x0101, 0x0202 with constant valid:
  - pe_load_ctrl = 80, 81, 82, 83, 7F, 7F on consecutive cycles, with matching pe_data.
  - A 4-PE behavioural chain holds weights 0x11/0x22/0x33/0x44 in PE0..PE3.
  - done pulses exactly 4 cycles after the last pe_valid cycle.
- Bubbles: drop s_tvalid for 2 cycles after the second weight → two cycles of 7F/0/pe_valid=0, then 82 continues. The PE model still loads correctly.
- vec_count=0: after the 4 weight handshakes → goes directly to DRAIN with no STREAM cycles; done after 4 cycles.
- cfg_start pulsed during STREAM with a different mode/count → ignored. Latched pe_simd_mode=1 persists; total streamed words equal the original count.
- NUM_PE=127 full load → final token 8'hFE, and no PE in a 127-deep model loads more than once.
